// File: rtl/game_round_ctrl_if.sv
// game_round_ctrl_if: player inputs and VGA/result outputs of game_round_ctrl
// master drives go/p1_choice/p2_choice; slave (the controller) drives pixel bus, winner, scores, busy
interface game_round_ctrl_if;
    logic       go;
    logic [2:0] p1_choice;
    logic [2:0] p2_choice;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [1:0] winner;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       busy;
    modport master (output go, p1_choice, p2_choice, input x, y, colour, plot, winner, score1, score2, busy);
    modport slave (input go, p1_choice, p2_choice, output x, y, colour, plot, winner, score1, score2, busy);
endinterface

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: two-player cat/dog/chicken round controller drawing a 16x16 result square
// clk: rising-edge clock; resetn: async active-low reset
// gr (slave): go, p1_choice, p2_choice in; x, y, colour, plot, winner, score1, score2, busy out
module game_round_ctrl (
    input  logic             clk,
    input  logic             resetn,
    game_round_ctrl_if.slave gr
);
    typedef enum logic [1:0] {IDLE, WAIT_P2, JUDGE, DRAW} state_t;
    state_t state, state_n;
    logic       go_q, go_edge, p1_ok, p2_ok, p1_beats, last_px, drawing;
    logic [2:0] p1_r, p2_r, colour_n;
    logic [1:0] result, sel, winner_r;
    logic [7:0] cnt, cnt_n, ox;
    logic [3:0] score1_r, score2_r;
    function automatic logic onehot3(input logic [2:0] c);
        return c == 3'b001 || c == 3'b010 || c == 3'b100;
    endfunction
    assign go_edge  = gr.go & ~go_q;
    assign p1_ok    = onehot3(gr.p1_choice);
    assign p2_ok    = onehot3(gr.p2_choice);
    assign p1_beats = (p1_r == 3'b010 && p2_r == 3'b001) ||
                      (p1_r == 3'b001 && p2_r == 3'b100) ||
                      (p1_r == 3'b100 && p2_r == 3'b010);
    assign result   = p1_r == p2_r ? 2'b11 : p1_beats ? 2'b01 : 2'b10;
    // the first pixel is issued on the JUDGE exit edge, before winner_r is updated
    assign sel      = state == JUDGE ? result : winner_r;
    assign ox       = sel == 2'b01 ? 8'd20 : sel == 2'b10 ? 8'd124 : 8'd72;
    assign colour_n = sel == 2'b01 ? 3'b100 : sel == 2'b10 ? 3'b001 : 3'b111;
    assign cnt_n    = state == JUDGE ? 8'd0 : cnt + 8'd1;
    assign last_px  = cnt == 8'hff;
    assign drawing  = state == JUDGE || (state == DRAW && !last_px);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go_edge && p1_ok) state_n = WAIT_P2;
            WAIT_P2: if (go_edge && p2_ok) state_n = JUDGE;
            JUDGE:   state_n = DRAW;
            DRAW:    if (last_px) state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            go_q     <= 1'b0;
            p1_r     <= 3'b000;
            p2_r     <= 3'b000;
            winner_r <= 2'b00;
            score1_r <= 4'd0;
            score2_r <= 4'd0;
            cnt      <= 8'd0;
            gr.plot  <= 1'b0;
            gr.x     <= 8'd0;
            gr.y     <= 7'd0;
            gr.colour <= 3'b000;
        end else begin
            go_q <= gr.go;
            if (state == IDLE && go_edge && p1_ok) p1_r <= gr.p1_choice;
            if (state == WAIT_P2 && go_edge && p2_ok) p2_r <= gr.p2_choice;
            if (state == JUDGE) begin
                winner_r <= result;
                if (result == 2'b01 && score1_r != 4'd15) score1_r <= score1_r + 4'd1;
                if (result == 2'b10 && score2_r != 4'd15) score2_r <= score2_r + 4'd1;
            end
            // cnt holds the {yoff,xoff} of the pixel currently on the bus
            if (drawing) begin
                cnt       <= cnt_n;
                gr.plot   <= 1'b1;
                gr.x      <= ox + {4'b0, cnt_n[3:0]};
                gr.y      <= 7'd50 + {3'b0, cnt_n[7:4]};
                gr.colour <= colour_n;
            end else begin
                cnt     <= 8'd0;
                gr.plot <= 1'b0;
            end
        end
    assign gr.winner = winner_r;
    assign gr.score1 = score1_r;
    assign gr.score2 = score2_r;
    assign gr.busy   = state == JUDGE || state == DRAW;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: scoreboard bench for game_round_ctrl
module tb_game_round_ctrl;
    localparam logic [2:0] CAT = 3'b001, DOG = 3'b010, CHICKEN = 3'b100;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    game_round_ctrl_if gr();
    game_round_ctrl dut (.clk(clk), .resetn(resetn), .gr(gr));
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    int plot_cycles = 0;
    logic [17:0] exp_q[$];
    logic [1:0] m_winner = 2'b00;
    logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [1:0] exp_result(input logic [2:0] a, input logic [2:0] b);
        if (a == b) return 2'b11;
        if ((a == DOG && b == CAT) || (a == CAT && b == CHICKEN) || (a == CHICKEN && b == DOG)) return 2'b01;
        return 2'b10;
    endfunction
    always @(negedge clk)
        if (resetn && gr.plot) begin
            plot_cycles++;
            if (exp_q.size() == 0) check("extra_pixel", 1, 0);
            else check("pixel", {gr.x, gr.y, gr.colour}, exp_q.pop_front());
        end
    task automatic check_reset_state();
        check("rst_plot", gr.plot, 0);
        check("rst_busy", gr.busy, 0);
        check("rst_x", gr.x, 0);
        check("rst_y", gr.y, 0);
        check("rst_colour", gr.colour, 0);
        check("rst_winner", gr.winner, 0);
        check("rst_score1", gr.score1, 0);
        check("rst_score2", gr.score2, 0);
    endtask
    task automatic press(input logic is_p2, input logic [2:0] c);
        @(negedge clk);
        if (is_p2) gr.p2_choice = c;
        else gr.p1_choice = c;
        gr.go = 1'b1;
        @(negedge clk);
        gr.go = 1'b0;
        @(negedge clk);
    endtask
    task automatic push_round(input logic [2:0] c1, input logic [2:0] c2);
        logic [1:0] r;
        logic [7:0] ox;
        logic [2:0] col;
        r = exp_result(c1, c2);
        ox = r == 2'b01 ? 8'd20 : r == 2'b10 ? 8'd124 : 8'd72;
        col = r == 2'b01 ? 3'b100 : r == 2'b10 ? 3'b001 : 3'b111;
        for (int yo = 0; yo < 16; yo++)
            for (int xo = 0; xo < 16; xo++)
                exp_q.push_back({ox + 8'(xo), 7'(50 + yo), col});
        m_winner = r;
        if (r == 2'b01 && m_s1 != 4'd15) m_s1 = m_s1 + 4'd1;
        if (r == 2'b10 && m_s2 != 4'd15) m_s2 = m_s2 + 4'd1;
        plot_cycles = 0;
    endtask
    task automatic finish_round(input logic toggle);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!gr.busy && !gr.plot) break;
            if (toggle) begin
                gr.go = ~gr.go;
                gr.p1_choice = ~gr.p1_choice;
                gr.p2_choice = ~gr.p2_choice;
            end
        end
        gr.go = 1'b0;
        check("draw_done", i < 400, 1);
        repeat (4) @(negedge clk);
        check("no_extra_round", gr.busy, 0);
        check("idle_plot", gr.plot, 0);
        check("plot_cycles", plot_cycles, 256);
        check("queue_empty", exp_q.size(), 0);
        check("winner", gr.winner, m_winner);
        check("score1", gr.score1, m_s1);
        check("score2", gr.score2, m_s2);
    endtask
    task automatic play_round(input logic [2:0] c1, input logic [2:0] c2, input logic toggle);
        press(1'b0, c1);
        push_round(c1, c2);
        press(1'b1, c2);
        finish_round(toggle);
    endtask
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check_reset_state();
        exp_q.delete();
        m_winner = 2'b00;
        m_s1 = 4'd0;
        m_s2 = 4'd0;
        @(negedge clk);
        resetn = 1'b1;
    endtask
    initial begin
        gr.go = 1'b0;
        gr.p1_choice = 3'b000;
        gr.p2_choice = 3'b000;
        #12;
        check_reset_state();
        @(negedge clk);
        resetn = 1'b1;
        play_round(DOG, CAT, 1'b0);
        play_round(CHICKEN, CHICKEN, 1'b0);
        press(1'b0, 3'b000);
        check("bad_p1_idle", gr.busy, 0);
        press(1'b0, DOG);
        press(1'b1, 3'b011);
        repeat (3) @(negedge clk);
        check("bad_p2_busy", gr.busy, 0);
        check("bad_p2_plot", gr.plot, 0);
        check("bad_p2_pixels", plot_cycles, 256);
        push_round(DOG, CHICKEN);
        press(1'b1, CHICKEN);
        finish_round(1'b0);
        play_round(CAT, DOG, 1'b1);
        play_round(CHICKEN, CAT, 1'b0);
        do_reset();
        for (int k = 0; k < 16; k++) play_round(CAT, DOG, 1'b0);
        check("sat_score2", gr.score2, 15);
        press(1'b0, DOG);
        push_round(DOG, CAT);
        press(1'b1, CAT);
        begin
            int i;
            for (i = 0; i < 400; i++) begin
                @(posedge clk);
                #2;
                if (plot_cycles >= 100) break;
            end
            check("mid_draw_reached", i < 400, 1);
        end
        do_reset();
        check("post_rst_plot", gr.plot, 0);
        check("post_rst_pixels", plot_cycles, 100);
        play_round(CAT, CHICKEN, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
